imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction-memory interface. Receives a framed byte stream
//   (e.g. from a UART RX) over a valid/ready handshake and assembles little-endian
//   32-bit words. It writes those words into the instruction-memory write port and
//   holds the single-cycle core in reset until a load completes with a good checksum.
// PARAMETERS
//   ADDR_WIDTH      10      imem word-address width; capacity = 2**ADDR_WIDTH words
//   TIMEOUT_CYCLES  100000  max idle cycles between accepted bytes mid-frame; 0 = disabled
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   rst          in   1           asynchronous, active-low reset
//   start        in   1           1-cycle pulse: begin a new load frame
//   rx_data      in   8           incoming byte
//   rx_valid     in   1           rx_data valid
//   rx_ready     out  1           loader can accept a byte this cycle
//   imem_we      out  1           imem write strobe, 1 cycle per word
//   imem_waddr   out  ADDR_WIDTH  imem word address
//   imem_wdata   out  32          imem write data
//   core_hold    out  1           1 = keep core in reset
//   done         out  1           sticky: last frame loaded with good checksum
//   error        out  1           sticky: last frame failed (length/checksum/timeout)
//   words_loaded out  ADDR_WIDTH+1 number of words written in current/last frame
// BEHAVIOUR
//   Frame: LEN_LO, LEN_HI (N = word count, 16b LE), 4*N payload bytes (LE words), CSUM.
//   CSUM = XOR of every preceding frame byte, including both length bytes.
//   Reset (rst=0): state IDLE. core_hold=1. rx_ready, imem_we, done, error = 0.
//     imem_waddr, imem_wdata, words_loaded, all counters and checksum = 0.
//   Byte accepted only on a cycle with rx_valid && rx_ready.
//   rx_ready = 1 exactly in LEN_LO, LEN_HI, DATA, CSUM (combinational from state).
//   States:
//     IDLE/DONE/ERROR --start--> LEN_LO. On entry: core_hold=1; done, error,
//       words_loaded, word_idx, byte_idx, checksum and timer cleared.
//     LEN_LO --accept--> LEN_HI.
//     LEN_HI --accept--> DATA if 1 <= N <= 2**ADDR_WIDTH, else ERROR (no writes).
//     DATA: byte k (0..3) goes to word[8k+:8]. On the 4th accepted byte:
//       - next cycle imem_we=1 for one cycle, imem_waddr=word_idx, imem_wdata=word
//       - word_idx and words_loaded increment in that same cycle
//       - after word N is accepted: DATA -> CSUM
//       DATA keeps accepting bytes back-to-back; write latency is 1 cycle.
//     CSUM --accept--> DONE if byte == checksum (done=1, core_hold=0).
//       On mismatch -> ERROR (error=1, core_hold stays 1). Written words are not rolled back.
//   Timeout: timer clears on each accepted byte and counts in LEN_LO..CSUM.
//     When timer reaches TIMEOUT_CYCLES -> ERROR.
//     If an accept and the timeout occur in the same cycle, the accept wins.
//   start while in LEN_LO..CSUM is ignored. start in DONE reasserts core_hold.
//   imem_waddr/imem_wdata hold their last value when imem_we=0.
//   word_idx never wraps: the length check bounds it to 2**ADDR_WIDTH-1.
//   Reset mid-frame: all state returns to reset values. The frame is abandoned, core_hold=1.
// TESTING
//   1. start; bytes 02 00 | 13 00 00 00 | 6F 00 00 00 | CSUM=0x7E
//      -> we at addr0 data 0x00000013, addr1 data 0x0000006F; done=1, core_hold=0, words_loaded=2
//   2. same frame with CSUM=0x00 -> both words written, error=1, done=0, core_hold=1
//   3. length 00 00, and separately length 0x0401 (ADDR_WIDTH=10)
//      -> ERROR after LEN_HI, imem_we never asserted
//   4. TIMEOUT_CYCLES=16; stall rx_valid 16 cycles after first payload byte
//      -> error=1, rx_ready=0; new start plus a full frame then gives done=1
//   5. rx_valid held high through a 1-word frame -> one byte accepted per cycle
//      -> imem_we exactly 1 cycle after 4th payload byte; start pulses mid-frame ignored
//   6. assert rst low mid-DATA -> outputs return to reset values asynchronously, state IDLE

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed little-endian byte stream into 32-bit words,
// writes them to imem and releases the core only after a load with a good checksum.
module imem_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST  = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [23:0]             word_q, word_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [31:0]             timer_q, timer_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic                    accept;
    logic                    timeout;
    logic                    len_ok;
    logic                    last_word;
    logic [16:0]             len_n;

    assign accept    = rx_valid && rx_ready;
    // An accept in the same cycle always beats the timeout.
    assign timeout   = TMO_EN && !accept && (timer_q == TMO_LAST);
    assign len_n     = {1'b0, rx_data, len_q[7:0]};
    assign len_ok    = (len_n != 17'd0) && (len_n <= MAX_WORDS);
    assign last_word = ((17'(cnt_q) + 17'd1) == {1'b0, len_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept)       state_d = S_LEN_HI;
                else if (timeout) state_d = S_ERROR;
            end
            S_LEN_HI: begin
                if (accept)       state_d = len_ok ? S_DATA : S_ERROR;
                else if (timeout) state_d = S_ERROR;
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx_q == 2'd3 && last_word) state_d = S_CSUM;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_CSUM: begin
                if (accept)       state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                else if (timeout) state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_ready = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    byte_idx_d = 2'd0;
                    csum_d     = 8'd0;
                    timer_d    = 32'd0;
                    cnt_d      = '0;
                end
            end
            default: begin
                if (accept)      timer_d = 32'd0;
                else if (TMO_EN) timer_d = timer_q + 32'd1;
                if (accept && state_q != S_CSUM) csum_d = csum_q ^ rx_data;
                if (accept) begin
                    case (state_q)
                        S_LEN_LO: len_d[7:0]  = rx_data;
                        S_LEN_HI: len_d[15:8] = rx_data;
                        S_DATA: begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            case (byte_idx_q)
                                2'd0: word_d[7:0]   = rx_data;
                                2'd1: word_d[15:8]  = rx_data;
                                2'd2: word_d[23:16] = rx_data;
                                default: begin
                                    // Fourth byte completes the word: issue the write next cycle.
                                    we_d    = 1'b1;
                                    waddr_d = cnt_q[ADDR_WIDTH-1:0];
                                    wdata_d = {rx_data, word_q};
                                    cnt_d   = cnt_q + (ADDR_WIDTH+1)'(1);
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            len_q      <= len_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, bad length, timeout, streaming, async reset.
module tb_imem_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            we_cnt = 0;
    int            log_cyc [16];
    logic [AW-1:0] log_addr[16];
    logic [31:0]   log_data[16];
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (we_cnt < 16) begin
                log_cyc[we_cnt]  = cyc;
                log_addr[we_cnt] = imem_waddr;
                log_data[we_cnt] = imem_wdata;
            end
            we_cnt++;
        end
    end

    int tests = 0;
    int fails = 0;
    int acc_cyc = 0;

    task automatic send_byte(input logic [7:0] b, input logic st);
        int n;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        start    = st;
        n = 0;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL send_byte %02h: rx_ready=%b after %0d cycles, required 1", b, rx_ready, n);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (rx_ready !== 1'b0)     begin fails++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        tests++; if (imem_we !== 1'b0)      begin fails++; $display("FAIL reset_we: got %b want 0", imem_we); end
        tests++; if (core_hold !== 1'b1)    begin fails++; $display("FAIL reset_core_hold: got %b want 1", core_hold); end
        tests++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_flags: done=%b error=%b want 0 0", done, error); end
        tests++; if (imem_waddr !== '0 || imem_wdata !== 32'h0 || words_loaded !== '0) begin
            fails++; $display("FAIL reset_regs: addr=%0h data=%08h words=%0d want 0", imem_waddr, imem_wdata, words_loaded);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL idle_rx_ready: got %b want 0", rx_ready); end
    endtask

    task automatic test_good_frame();
        int w0;
        w0 = we_cnt;
        pulse_start();
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL good_len_lo_ready: got %b want 1", rx_ready); end
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h6F, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h7E, 1'b0);
        end_stream();
        tests++; if (we_cnt - w0 !== 2) begin fails++; $display("FAIL good_we_count: got %0d want 2", we_cnt - w0); end
        tests++; if (log_addr[w0] !== 10'd0 || log_data[w0] !== 32'h0000_0013) begin
            fails++; $display("FAIL good_word0: addr=%0h data=%08h want 0 00000013", log_addr[w0], log_data[w0]);
        end
        tests++; if (log_addr[w0+1] !== 10'd1 || log_data[w0+1] !== 32'h0000_006F) begin
            fails++; $display("FAIL good_word1: addr=%0h data=%08h want 1 0000006f", log_addr[w0+1], log_data[w0+1]);
        end
        tests++; if (done !== 1'b1 || error !== 1'b0 || core_hold !== 1'b0) begin
            fails++; $display("FAIL good_status: done=%b error=%b hold=%b want 1 0 0", done, error, core_hold);
        end
        tests++; if (words_loaded !== 11'd2) begin fails++; $display("FAIL good_words_loaded: got %0d want 2", words_loaded); end
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL good_done_ready: got %b want 0", rx_ready); end
    endtask

    task automatic test_bad_csum();
        int w0;
        w0 = we_cnt;
        pulse_start();
        tests++; if (core_hold !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL restart_from_done: hold=%b done=%b want 1 0", core_hold, done);
        end
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h6F, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        end_stream();
        tests++; if (we_cnt - w0 !== 2) begin fails++; $display("FAIL bad_csum_we_count: got %0d want 2", we_cnt - w0); end
        tests++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
            fails++; $display("FAIL bad_csum_status: error=%b done=%b hold=%b want 1 0 1", error, done, core_hold);
        end
    endtask

    task automatic test_bad_length();
        int w0;
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        end_stream();
        tests++; if (error !== 1'b1 || rx_ready !== 1'b0) begin
            fails++; $display("FAIL len_zero: error=%b rx_ready=%b want 1 0", error, rx_ready);
        end
        pulse_start();
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL restart_clears_error: got %b want 0", error); end
        send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
        end_stream();
        tests++; if (error !== 1'b1 || rx_ready !== 1'b0) begin
            fails++; $display("FAIL len_too_big: error=%b rx_ready=%b want 1 0", error, rx_ready);
        end
        tests++; if (we_cnt !== w0 || words_loaded !== 11'd0) begin
            fails++; $display("FAIL len_no_writes: writes=%0d words=%0d want 0 0", we_cnt - w0, words_loaded);
        end
    endtask

    task automatic test_timeout();
        int w0;
        pulse_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b0);
        end_stream();
        repeat (15) @(negedge clk);
        tests++; if (error !== 1'b0 || rx_ready !== 1'b1) begin
            fails++; $display("FAIL timeout_early: error=%b rx_ready=%b want 0 1", error, rx_ready);
        end
        @(negedge clk);
        tests++; if (error !== 1'b1 || rx_ready !== 1'b0) begin
            fails++; $display("FAIL timeout_hit: error=%b rx_ready=%b want 1 0", error, rx_ready);
        end
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_byte(8'h01, 1'b0);
        end_stream();
        tests++; if (done !== 1'b1 || error !== 1'b0) begin
            fails++; $display("FAIL timeout_recover: done=%b error=%b want 1 0", done, error);
        end
        tests++; if (we_cnt - w0 !== 1 || log_addr[w0] !== 10'd0 || log_data[w0] !== 32'hDDCC_BBAA) begin
            fails++; $display("FAIL timeout_recover_word: n=%0d addr=%0h data=%08h want 1 0 ddccbbaa",
                              we_cnt - w0, log_addr[w0], log_data[w0]);
        end
    endtask

    task automatic test_back_to_back();
        int w0, a0, a3;
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h78, 1'b0); a0 = acc_cyc;
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b1); a3 = acc_cyc;
        send_byte(8'h09, 1'b1);
        end_stream();
        tests++; if (a3 - a0 !== 3) begin fails++; $display("FAIL b2b_rate: got %0d cycles for 4 bytes want 3", a3 - a0); end
        tests++; if (we_cnt - w0 !== 1) begin fails++; $display("FAIL b2b_we_count: got %0d want 1", we_cnt - w0); end
        tests++; if (log_cyc[w0] !== a3) begin
            fails++; $display("FAIL b2b_write_latency: write at cycle %0d want %0d", log_cyc[w0], a3);
        end
        tests++; if (log_data[w0] !== 32'h1234_5678 || log_addr[w0] !== 10'd0) begin
            fails++; $display("FAIL b2b_word: addr=%0h data=%08h want 0 12345678", log_addr[w0], log_data[w0]);
        end
        tests++; if (done !== 1'b1 || words_loaded !== 11'd1) begin
            fails++; $display("FAIL b2b_start_ignored: done=%b words=%0d want 1 1", done, words_loaded);
        end
    endtask

    task automatic test_async_reset();
        int w0;
        pulse_start();
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hC3, 1'b0); send_byte(8'hD4, 1'b0);
        send_byte(8'hE5, 1'b0);
        tests++; if (imem_wdata !== 32'hD4C3_B2A1 || words_loaded !== 11'd1) begin
            fails++; $display("FAIL pre_reset: data=%08h words=%0d want d4c3b2a1 1", imem_wdata, words_loaded);
        end
        #1;
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests++; if (rx_ready !== 1'b0 || imem_we !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL async_reset_ctrl: ready=%b we=%b hold=%b done=%b error=%b want 0 0 1 0 0",
                              rx_ready, imem_we, core_hold, done, error);
        end
        tests++; if (imem_wdata !== 32'h0 || imem_waddr !== '0 || words_loaded !== '0) begin
            fails++; $display("FAIL async_reset_regs: data=%08h addr=%0h words=%0d want 0", imem_wdata, imem_waddr, words_loaded);
        end
        @(negedge clk);
        rst = 1'b1;
        w0 = we_cnt;
        repeat (3) @(negedge clk);
        tests++; if (rx_ready !== 1'b0 || we_cnt !== w0) begin
            fails++; $display("FAIL after_reset_idle: ready=%b writes=%0d want 0 0", rx_ready, we_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_length();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
